// File: rtl/i2c_mst_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_mst_arbiter
//   Shares one I2C master core between NUM_REQ requesters. A granted request
//   (16-bit control word + 128-bit write payload) is copied into registers and
//   presented to the core on mst_ctrl/mst_wfifo. The block then tracks the
//   core busy flag and returns read data plus a timeout flag to the owner.
//
//   Build option: define I2C_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins). Default build is round-robin.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_valid[N]         requester i has a transfer pending
//   req_ready[N]         one-cycle accept pulse to the granted requester
//   req_ctrl[16*N]       slice i: [15:9] addr, [8] rd_wr, [3:0] len-1
//   req_wdata[128*N]     slice i: write payload, MSB byte first
//   rsp_valid[N]         one-cycle completion pulse to the owner
//   rsp_rdata[128]       read data, meaningful with rsp_valid
//   rsp_err              timeout flag, meaningful with rsp_valid
//   mst_ctrl[16]         to core: {addr, rd_wr, pld_rdy, 3'b0, len-1}
//   mst_wfifo[128]       to core: registered payload
//   mst_rfifo[128]       from core: read data
//   mst_status[8]        from core: [7] busy
// ---------------------------------------------------------------------------
module i2c_mst_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [16*NUM_REQ-1:0]    req_ctrl,
  input  logic [128*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [127:0]             rsp_rdata,
  output logic                     rsp_err,
  output logic [15:0]              mst_ctrl,
  output logic [127:0]             mst_wfifo,
  input  logic [127:0]             mst_rfifo,
  input  logic [7:0]               mst_status
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t           state;
  logic [15:0]      timer;
  logic [IDX_W-1:0] owner;
  logic             busy;
  logic             busy_q;
  logic             any_req;
  logic [IDX_W-1:0] win;
  logic [15:0]      sel_ctrl;
  logic [127:0]     sel_wdata;
  logic             timer_hit;

  assign busy      = mst_status[7];
  assign any_req   = |req_valid;
  assign sel_ctrl  = req_ctrl[int'(win)*16 +: 16];
  assign sel_wdata = req_wdata[int'(win)*128 +: 128];
  // A phase lasts exactly TIMEOUT_CYC cycles: the expiring cycle is the one
  // in which the timer would step onto TIMEOUT_CYC.
  assign timer_hit = (timer == TIMEOUT_CYC - 16'd1);

  // Status bits other than busy and the reserved control nibble are ignored.
  logic unused_bits;
  assign unused_bits = ^{mst_status[6:0], sel_ctrl[7:4]};

  // Requester handshake: a request is pending while req_valid[i] is high.
  // The arbiter accepts it with a single-cycle req_ready[i] pulse and copies
  // ctrl/wdata in that same cycle; req_valid[i] may drop afterwards. A request
  // withdrawn before the pulse is simply never transferred. Completion comes
  // back later as a single-cycle rsp_valid[i] pulse with rsp_rdata/rsp_err.

`ifdef I2C_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest pending index wins.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win = IDX_W'(i);
    end
  end
`else
  // Round-robin: search starts one past the last winner and wraps.
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int  idx;
    logic found;
    win   = '0;
    idx   = 0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (state == ST_IDLE && any_req && !busy) begin
      rr_ptr <= win;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      owner     <= '0;
      busy_q    <= 1'b0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mst_ctrl  <= '0;
      mst_wfifo <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      busy_q    <= busy;
      timer     <= (timer == TIMEOUT_CYC) ? timer : timer + 16'd1;

      case (state)
        ST_IDLE: begin
          if (any_req && !busy) begin
            req_ready <= NUM_REQ'(1) << win;
            owner     <= win;
            mst_ctrl  <= {sel_ctrl[15:8], 1'b1, 3'b000, sel_ctrl[3:0]};
            mst_wfifo <= sel_wdata;
            timer     <= '0;
            state     <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (busy) begin
            mst_ctrl[7] <= 1'b0;
            timer       <= '0;
            state       <= ST_RUN;
          end else if (timer_hit) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= NUM_REQ'(1) << owner;
            timer     <= '0;
            state     <= ST_RESP;
          end
        end

        // busy_q was 1 on entry, so a 0 here is the core's busy fall seen
        // through the sampling flop: capture, then respond.
        ST_RUN: begin
          if (!busy_q) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= mst_rfifo;
            rsp_valid <= NUM_REQ'(1) << owner;
            timer     <= '0;
            state     <= ST_RESP;
          end else if (timer_hit) begin
            timer <= '0;
            state <= ST_DRAIN;
          end
        end

        // The core is still on the bus; the payload must stay put until it
        // lets go, then report the timeout with no data.
        ST_DRAIN: begin
          if (!busy_q) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            rsp_valid <= NUM_REQ'(1) << owner;
            timer     <= '0;
            state     <= ST_RESP;
          end
        end

        ST_RESP: begin
          mst_ctrl  <= '0;
          mst_wfifo <= '0;
          timer     <= '0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mst_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_mst_arbiter
//   Directed bench for i2c_mst_arbiter. Two instances share clock, reset and
//   the core-side inputs: dut_a uses the default timeout, dut_b a 16-cycle
//   timeout. Only the instance selected by 'sel' sees requests; outputs are
//   observed through a mux on 'sel'.
// ---------------------------------------------------------------------------
module tb_i2c_mst_arbiter;
  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 sel = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [16*N-1:0]      req_ctrl = '0;
  logic [128*N-1:0]     req_wdata = '0;
  logic [127:0]         mst_rfifo = '0;
  logic [7:0]           mst_status = '0;

  logic [N-1:0]   a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid;
  logic [127:0]   a_rsp_rdata, b_rsp_rdata, a_mst_wfifo, b_mst_wfifo;
  logic           a_rsp_err, b_rsp_err;
  logic [15:0]    a_mst_ctrl, b_mst_ctrl;
  logic [N-1:0]   a_req_valid, b_req_valid;

  logic [N-1:0]   req_ready, rsp_valid;
  logic [127:0]   rsp_rdata, mst_wfifo;
  logic           rsp_err;
  logic [15:0]    mst_ctrl;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign a_req_valid = sel ? '0 : req_valid;
  assign b_req_valid = sel ? req_valid : '0;

  assign req_ready = sel ? b_req_ready : a_req_ready;
  assign rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign rsp_err   = sel ? b_rsp_err   : a_rsp_err;
  assign mst_ctrl  = sel ? b_mst_ctrl  : a_mst_ctrl;
  assign mst_wfifo = sel ? b_mst_wfifo : a_mst_wfifo;

  i2c_mst_arbiter #(.NUM_REQ(N)) dut_a (
    .clk(clk), .rstn(rstn),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mst_ctrl(a_mst_ctrl), .mst_wfifo(a_mst_wfifo),
    .mst_rfifo(mst_rfifo), .mst_status(mst_status)
  );

  i2c_mst_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16'd16)) dut_b (
    .clk(clk), .rstn(rstn),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_ctrl(req_ctrl), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mst_ctrl(b_mst_ctrl), .mst_wfifo(b_mst_wfifo),
    .mst_rfifo(mst_rfifo), .mst_status(mst_status)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic issue(input int idx, input logic [15:0] c, input logic [127:0] w);
    req_ctrl[idx*16 +: 16]    = c;
    req_wdata[idx*128 +: 128] = w;
    req_valid[idx]            = 1'b1;
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (req_ready == '0 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == '0 && n < max);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  localparam logic [127:0] W0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] W1 = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] W2 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] RD = 128'h55AA << 112;

  initial begin
    int n;
    int seen;
    logic [N-1:0] e;

    // reset state
    @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_rdata", rsp_rdata, 128'(0));
    chk("rst_rsp_err",   128'(rsp_err), 128'(0));
    chk("rst_mst_ctrl",  128'(mst_ctrl), 128'(0));
    chk("rst_mst_wfifo", mst_wfifo, 128'(0));
    rstn = 1'b1;
    @(negedge clk);

    // 1: single write from requester 0
    issue(0, 16'hA003, W0);
    @(negedge clk);
    chk("t1_ready",       128'(req_ready), 128'(4'b0001));
    chk("t1_ctrl_launch", 128'(mst_ctrl), 128'(16'hA083));
    chk("t1_wfifo",       mst_wfifo, W0);
    req_valid = '0;
    @(negedge clk);
    chk("t1_ready_pulse", 128'(req_ready), 128'(0));
    chk("t1_ctrl_hold",   128'(mst_ctrl), 128'(16'hA083));
    mst_status = 8'h80;
    @(negedge clk);
    chk("t1_ctrl_run", 128'(mst_ctrl), 128'(16'hA003));
    repeat (39) @(negedge clk);
    chk("t1_no_rsp_busy", 128'(rsp_valid), 128'(0));
    chk("t1_wfifo_run",   mst_wfifo, W0);
    mst_status = 8'h00;
    wait_rsp(10, n);
    chk("t1_rsp_lat",   128'(n), 128'(2));
    chk("t1_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("t1_rsp_err",   128'(rsp_err), 128'(0));
    chk("t1_rsp_rdata", rsp_rdata, 128'(0));
    @(negedge clk);
    chk("t1_rsp_pulse", 128'(rsp_valid), 128'(0));
    chk("t1_ctrl_idle", 128'(mst_ctrl), 128'(0));
    chk("t1_wfifo_idle", mst_wfifo, 128'(0));

    // 2: read from requester 2
    issue(2, 16'hA101, W2);
    wait_ready(5, n);
    chk("t2_ready", 128'(req_ready), 128'(4'b0100));
    chk("t2_ctrl",  128'(mst_ctrl), 128'(16'hA181));
    req_valid = '0;
    mst_status = 8'h80;
    repeat (5) @(negedge clk);
    mst_rfifo  = RD;
    mst_status = 8'h00;
    wait_rsp(10, n);
    chk("t2_rsp_lat",   128'(n), 128'(2));
    chk("t2_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("t2_rsp_rdata", rsp_rdata, RD);
    chk("t2_rsp_err",   128'(rsp_err), 128'(0));
    mst_rfifo = '0;
    @(negedge clk);

    // 3: fairness with all requesters pending
    do_reset();
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
`ifdef I2C_ARB_FIXED_PRIO_EN
      e = 4'b0001;
`else
      e = 4'(1) << (k % 4);
`endif
      wait_ready(20, n);
      chk($sformatf("t3_grant%0d", k), 128'(req_ready), 128'(e));
      mst_status = 8'h80;
      repeat (3) @(negedge clk);
      mst_status = 8'h00;
      wait_rsp(10, n);
      if (k == 7) req_valid = '0;
      chk($sformatf("t3_rsp%0d", k), 128'(rsp_valid), 128'(e));
    end
    @(negedge clk);

    // 4: launch timeout on the 16-cycle instance
    sel = 1'b1;
    issue(1, 16'h5205, W1);
    wait_ready(5, n);
    chk("t4_ready", 128'(req_ready), 128'(4'b0010));
    chk("t4_ctrl",  128'(mst_ctrl), 128'(16'h5285));
    req_valid = '0;
    wait_rsp(40, n);
    chk("t4_rsp_lat",   128'(n), 128'(16));
    chk("t4_rsp_valid", 128'(rsp_valid), 128'(4'b0010));
    chk("t4_rsp_err",   128'(rsp_err), 128'(1));
    @(negedge clk);
    chk("t4_ctrl_idle", 128'(mst_ctrl), 128'(0));

    // 5: run timeout, core stays busy for 100 cycles
    issue(3, 16'h7107, W2);
    wait_ready(5, n);
    chk("t5_ready", 128'(req_ready), 128'(4'b1000));
    req_valid  = '0;
    mst_status = 8'h80;
    mst_rfifo  = '1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    chk("t5_no_rsp_busy", 128'(seen), 128'(0));
    chk("t5_ctrl_drain",  128'(mst_ctrl), 128'(16'h7107));
    chk("t5_wfifo_drain", mst_wfifo, W2);
    mst_status = 8'h00;
    wait_rsp(10, n);
    chk("t5_rsp_lat",   128'(n), 128'(2));
    chk("t5_rsp_valid", 128'(rsp_valid), 128'(4'b1000));
    chk("t5_rsp_err",   128'(rsp_err), 128'(1));
    chk("t5_rsp_rdata", rsp_rdata, 128'(0));
    mst_rfifo = '0;
    @(negedge clk);
    sel = 1'b0;

    // 6: reset in the middle of RUN
    issue(1, 16'h3300, W1);
    wait_ready(5, n);
    chk("t6_ready", 128'(req_ready), 128'(4'b0010));
    req_valid  = '0;
    mst_status = 8'h80;
    repeat (4) @(negedge clk);
    chk("t6_ctrl_run", 128'(mst_ctrl), 128'(16'h3300));
    rstn = 1'b0;
    #1;
    chk("t6_rst_req_ready", 128'(req_ready), 128'(0));
    chk("t6_rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("t6_rst_rsp_err",   128'(rsp_err), 128'(0));
    chk("t6_rst_rsp_rdata", rsp_rdata, 128'(0));
    chk("t6_rst_mst_ctrl",  128'(mst_ctrl), 128'(0));
    chk("t6_rst_mst_wfifo", mst_wfifo, 128'(0));
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != '0) seen++;
    end
    mst_status = 8'h00;
    rstn = 1'b1;
    req_valid = 4'hF;
    wait_ready(5, n);
    chk("t6_grant_after_rst", 128'(req_ready), 128'(4'b0001));
    req_valid  = '0;
    mst_status = 8'h80;
    repeat (2) @(negedge clk);
    mst_status = 8'h00;
    wait_rsp(10, n);
    if (rsp_valid != '0 && rsp_valid != 4'b0001) seen++;
    chk("t6_rsp_after_rst", 128'(rsp_valid), 128'(4'b0001));
    chk("t6_no_stale_rsp",  128'(seen), 128'(0));
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
